// File: rtl/mux_nx1_reg_if.sv
// Handshake bundle for mux_nx1_reg: N valid/ready producer channels and one registered consumer.
// The slave modport is the selector; the master modport drives producers and the consumer.
interface mux_nx1_reg_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) ();
   logic [WIDTH-1:0] in [N-1:0];
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [SELW-1:0]  sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic [SELW-1:0]  out_sel;

   modport master (
      output in, in_valid, sel, out_ready,
      input  in_ready, out, out_valid, out_sel
   );

   modport slave (
      input  in, in_valid, sel, out_ready,
      output in_ready, out, out_valid, out_sel
   );
endinterface

// File: rtl/mux_nx1_reg.sv
// Registered N:1 word selector with valid/ready on every channel and on the output.
// MODE 0 takes the channel index from sel; MODE 1 arbitrates round-robin from ptr.
module mux_nx1_reg #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 4,
   parameter int unsigned MODE  = 0,
   parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
   input logic          clk,
   input logic          reset_n,
   mux_nx1_reg_if.slave bus
);
   logic [WIDTH-1:0] out_q, out_d;
   logic [SELW-1:0]  out_sel_q, out_sel_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic [SELW-1:0]  tgt_idx;
   logic             tgt_ok;
   logic             grant;
   logic             load;
   logic [WIDTH-1:0] grant_data;
   int unsigned      cand;

   assign load = !out_valid_q || bus.out_ready;

   // tgt_* names the one channel that may see ready; in MODE 0 that is independent of in_valid.
   always_comb begin
      tgt_idx = '0;
      tgt_ok  = 1'b0;
      cand    = 0;
      if (MODE == 0) begin
         if (N == 1) begin
            tgt_ok = 1'b1;
         end else if (32'(bus.sel) < N) begin
            tgt_idx = bus.sel;
            tgt_ok  = 1'b1;
         end
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) begin
               cand = cand - N;
            end
            if (!tgt_ok && bus.in_valid[cand]) begin
               tgt_ok  = 1'b1;
               tgt_idx = SELW'(cand);
            end
         end
      end
   end

   assign grant = tgt_ok && bus.in_valid[tgt_idx];

   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (tgt_idx == SELW'(i)) begin
            grant_data = bus.in[i];
         end
      end
   end

   always_comb begin
      bus.in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         bus.in_ready[i] = reset_n && load && tgt_ok && (tgt_idx == SELW'(i));
      end
   end

   always_comb begin
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load && grant) begin
         out_d       = grant_data;
         out_sel_d   = tgt_idx;
         out_valid_d = 1'b1;
         if (MODE != 0) begin
            ptr_d = (32'(tgt_idx) == N - 1) ? '0 : tgt_idx + 1'b1;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_q       <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_q       <= out_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg: one explicit-select and one round-robin instance, each with a
// scoreboard queue filled on modelled input transfers and drained on output handshakes.
module tb_mux_nx1_reg;
   localparam int unsigned W  = 64;
   localparam int unsigned N  = 4;
   localparam int unsigned SW = 2;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] idx;
   } item_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mux_nx1_reg_if #(.WIDTH(W), .N(N), .SELW(SW)) bus0 ();
   mux_nx1_reg_if #(.WIDTH(W), .N(N), .SELW(SW)) bus1 ();

   mux_nx1_reg #(.WIDTH(W), .N(N), .MODE(0), .SELW(SW)) u_sel (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus0)
   );

   mux_nx1_reg #(.WIDTH(W), .N(N), .MODE(1), .SELW(SW)) u_rr (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus1)
   );

   item_t       q0[$];
   item_t       q1[$];
   int          rr_log[$];
   int unsigned rr_ptr;
   int          n_checks;
   int          n_errs;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with inputs already set; evaluates handshakes, then advances one cycle.
   task automatic tick();
      logic        load0, load1;
      logic [N-1:0] exp_rdy0, exp_rdy1;
      int          g1;
      int unsigned c;
      item_t       it;
      #1;
      check_eq("out_valid0", bus0.out_valid, q0.size() != 0);
      check_eq("out_valid1", bus1.out_valid, q1.size() != 0);
      load0    = (q0.size() == 0) || bus0.out_ready;
      load1    = (q1.size() == 0) || bus1.out_ready;
      exp_rdy0 = '0;
      exp_rdy1 = '0;
      g1       = -1;
      for (int k = 0; k < N; k++) begin
         c = (rr_ptr + k) % N;
         if (g1 < 0 && bus1.in_valid[c]) g1 = int'(c);
      end
      if (reset_n) begin
         if (load0) exp_rdy0[bus0.sel] = 1'b1;
         if (load1 && g1 >= 0) exp_rdy1[g1] = 1'b1;
      end
      check_eq("in_ready0", bus0.in_ready, exp_rdy0);
      check_eq("in_ready1", bus1.in_ready, exp_rdy1);
      if (reset_n) begin
         if (q0.size() != 0 && bus0.out_ready) begin
            it = q0.pop_front();
            check_eq("out0", bus0.out, it.data);
            check_eq("out_sel0", bus0.out_sel, it.idx);
         end
         if (q1.size() != 0 && bus1.out_ready) begin
            it = q1.pop_front();
            check_eq("out1", bus1.out, it.data);
            check_eq("out_sel1", bus1.out_sel, it.idx);
            rr_log.push_back(int'(bus1.out_sel));
         end
         if (load0 && bus0.in_valid[bus0.sel]) q0.push_back({bus0.in[bus0.sel], bus0.sel});
         if (load1 && g1 >= 0) begin
            q1.push_back({bus1.in[g1], SW'(g1)});
            rr_ptr = (g1 + 1) % N;
         end
      end
      @(posedge clk);
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         rr_ptr = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      int seq_sel[4] = '{2, 0, 3, 1};
      int rr_exp[5]  = '{2, 0, 1, 0, 1};
      n_checks = 0;
      n_errs   = 0;
      rr_ptr   = 0;
      reset_n  = 1'b0;
      bus0.sel = '0;
      bus1.sel = '0;
      bus0.in_valid  = '1;
      bus1.in_valid  = '1;
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         bus0.in[k] = 64'hA000_0000_0000_0000 | 64'(k);
         bus1.in[k] = 64'hB000_0000_0000_0000 | 64'(k);
      end
      @(posedge clk);
      @(negedge clk);
      tick();
      tick();
      check_eq("rst_out0", bus0.out, '0);
      check_eq("rst_sel0", bus0.out_sel, '0);
      check_eq("rst_out1", bus1.out, '0);
      check_eq("rst_sel1", bus1.out_sel, '0);
      reset_n = 1'b1;

      // Explicit select on u_sel while u_rr runs its fairness sequence.
      for (int i = 0; i < 8; i++) begin
         if (i < 4) bus0.sel = SW'(seq_sel[i]);
         else bus0.in_valid = '0;
         tick();
      end
      bus1.in_valid = '0;
      tick();
      tick();
      check_eq("rr_fair_cnt", rr_log.size(), 8);
      for (int i = 0; i < 8 && i < rr_log.size(); i++) check_eq("rr_fair", rr_log[i], i % 4);

      // Back-pressure on u_sel.
      bus0.sel      = 2'd1;
      bus0.in_valid = 4'b0010;
      bus0.in[1]    = 64'hDEAD_BEEF_0000_0001;
      tick();
      bus0.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus0.in[1] = 64'h5555_0000_0000_0000 | 64'(i);
         tick();
         check_eq("hold_out0", bus0.out, 64'hDEAD_BEEF_0000_0001);
      end
      bus0.out_ready = 1'b1;
      tick();
      bus0.in_valid = '0;
      tick();
      tick();

      // Round-robin skip and wrap, then ptr must be untouched by idle cycles.
      rr_log.delete();
      bus1.in_valid = 4'b0100;
      tick();
      bus1.in_valid = 4'b0011;
      tick();
      tick();
      tick();
      bus1.in_valid = '0;
      tick();
      tick();
      tick();
      bus1.in_valid = '1;
      tick();
      bus1.in_valid = '0;
      tick();
      tick();
      check_eq("rr_skip_cnt", rr_log.size(), 5);
      for (int i = 0; i < 5 && i < rr_log.size(); i++) check_eq("rr_skip", rr_log[i], rr_exp[i]);

      // Reset while both instances stall on a held word.
      bus1.in[1]    = 64'h1234;
      bus1.in_valid = 4'b0010;
      bus0.in[3]    = 64'h1234;
      bus0.sel      = 2'd3;
      bus0.in_valid = 4'b1000;
      tick();
      bus0.in_valid  = '0;
      bus1.in_valid  = '0;
      bus0.out_ready = 1'b0;
      bus1.out_ready = 1'b0;
      tick();
      check_eq("stall_out0", bus0.out, 64'h1234);
      check_eq("stall_out1", bus1.out, 64'h1234);
      reset_n = 1'b0;
      tick();
      reset_n        = 1'b1;
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      check_eq("mid_rst_out0", bus0.out, '0);
      check_eq("mid_rst_out1", bus1.out, '0);
      check_eq("mid_rst_sel1", bus1.out_sel, '0);
      rr_log.delete();
      bus1.in_valid = '1;
      tick();
      bus1.in_valid = '0;
      tick();
      tick();
      check_eq("ptr_rst_cnt", rr_log.size(), 1);
      if (rr_log.size() > 0) check_eq("ptr_rst", rr_log[0], 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised registered N:1 word selector. Successor to the combinational 64-bit 2:1 datapath mux.
- Generalised in width and channel count. Adds a valid/ready handshake on every input channel and on the output.
- Adds two select modes: explicit select and round-robin arbitration.
- Sits between multiple producers (forwarding paths, writeback sources, memory response ports) and a single registered consumer stage.

Parameters:
- WIDTH, 64, data bits per channel.
- N, 4, number of input channels (>=1).
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration (sel ignored).
- SELW, max(1,$clog2(N)), width of sel/out_sel (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in  input  N x WIDTH (unpacked [N-1:0] of [WIDTH-1:0])  channel data.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; a channel transfers when in_valid[i] && in_ready[i].
- sel  input  SELW  channel index (MODE 0 only).
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out holds an undelivered word.
- out_ready  input  1  consumer accepts out this cycle.
- out_sel  output  SELW  index of the channel that produced out.

Behaviour:
- Reset: applied when reset_n=0 at a clk edge; sampled synchronously.
  - Effect: out=0, out_valid=0, out_sel=0, round-robin pointer ptr=0.
  - A word held mid-operation is dropped, not delivered.
  - in_ready is forced 0 while reset_n=0.
- Load enable: load = !out_valid || out_ready. The output register may take a new word only when load=1.
- Grant (combinational, one channel at most):
  - MODE 0: grant = sel if sel<N and in_valid[sel]; otherwise no grant. Out-of-range sel (N not a power of 2) never grants.
  - MODE 1: grant = first i with in_valid[i], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap). No grant if all in_valid=0.
- in_ready[i] = reset_n && load && (i == grant index):
  - MODE 0: in_ready[sel] = load regardless of in_valid. All other channels are 0.
  - MODE 1: only the granted channel sees ready.
- Transfer into register on a clk edge when load && grant: out<=in[g], out_sel<=g, out_valid<=1.
- Drain: if out_valid && out_ready and there is no new grant, out_valid<=0. out/out_sel hold their last values.
- Simultaneous drain and refill (out_valid && out_ready && grant): the new word replaces the old in the same edge. Sustained throughput is 1 word/cycle.
- Stall: out_valid && !out_ready means out, out_sel and out_valid hold, and all in_ready=0.
- Latency: exactly 1 cycle from input transfer to out_valid.
- ptr update (MODE 1 only): on each input transfer, ptr <= (g==N-1) ? 0 : g+1. Otherwise ptr holds. In MODE 0 ptr stays 0.
- N=1: sel is ignored (treated as 0). The block degenerates to a 1-entry pipeline register.
- No combinational path from in/in_valid to out/out_valid. in_ready depends combinationally on out_ready, in_valid (MODE 1) and sel (MODE 0).

Test Plan:
- Reset: reset_n=0 for 2 cycles with all in_valid=1, out_ready=1 -> out_valid=0, out=0, out_sel=0, in_ready=0000. After release, the first transfer occurs on the next edge.
- MODE 0 select, N=4, WIDTH=64:
  - in[k]=64'hA0..0k, all in_valid=1, out_ready=1, sel stepping 2,0,3,1 on successive cycles.
  - Expect out = 64'h..02, ..00, ..03, ..01, one cycle later each, with out_sel matching and out_valid continuously 1.
- Back-pressure: MODE 0, sel=1, word 64'hDEAD_BEEF_0000_0001 captured, then out_ready=0 for 3 cycles while in[1] changes.
  - Expect out held at DEAD_BEEF_0000_0001 and in_ready=0000 throughout.
  - Raising out_ready delivers that word and loads the new in[1] on the same edge.
- Round-robin fairness: MODE 1, N=4, all in_valid=1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
- Round-robin skip and wrap: MODE 1, ptr=3 (after granting ch2), in_valid=0011 -> grant ch0, then ch1, then ch0. in_valid=0000 -> out_valid drops after the held word drains; ptr is unchanged.
- Reset mid-stall: out_valid=1 and out_ready=0 holding 64'h1234, pulse reset_n=0 for one edge -> out_valid=0, out=0, ptr=0. The held word is never delivered.
